cf_output_collector: RTL and testbench
======================================

# cf_output_collector

Collects the 16-word chaining values (C) produced by successive MD6 compression-function instances and packs four consecutive children into the 64-word message block consumed by the next tree level. It is the consumer end of the CF datapath, the reverse of the N-vector builder: that block splits a 64-word B into compression input, and this block rebuilds a 64-word M_in from compression outputs. It also supplies the parent level, parent index and padding count that the N builder needs for the next CF.

## Interface
Parameters
- W, 64: word width; equals `w` from `parameters.vh`.
- CV_WORDS, 16: words per chaining value.
- FANIN, 4: chaining values per parent block. Fixed at 4; other values are unsupported.

Ports
- clk  in  1  clock. The block has one clock; all logic is rising-edge.
- rst_n  in  1  reset, asynchronous and active-low.
- c_data  in  CV_WORDS*W  chaining value from the CF.
- c_valid  in  1  c_data and its qualifiers are valid.
- c_ready  out  1  collector accepts the CV this cycle.
- c_level  in  8  tree level of the producing CF.
- c_index  in  56  index of the producing CF within its level.
- c_last  in  1  this CV is the last one of its level.
- m_data  out  64*W  assembled parent block, i.e. M_in for the next level.
- m_valid  out  1  m_data and its qualifiers are valid.
- m_ready  in  1  downstream accepts the block.
- m_level  out  8  parent level, equal to c_level+1 with 8-bit wrap.
- m_index  out  56  parent index, equal to the first child's c_index >> 2.
- m_last  out  1  this is the last parent block of its level.
- padding_zero_M  out  12  number of zero-padded bits in m_data.
- err  out  1  sticky consistency error.

## Operation
- State machine:
  - FILL: c_ready=1, m_valid=0.
  - EMIT: c_ready=0, m_valid=1.
- Slot counter `slot` is 2 bits; it counts CVs accepted into the current block.
- An accept in FILL happens when c_valid && c_ready. On accept:
  - c_data is written to slot s. Slot s occupies bits [(64-16s)*W-1 : (48-16s)*W], so the first child lands in the most significant quarter.
  - On the first accept of a block (slot=0), the block latches m_level = c_level+1, m_index = c_index>>2 and m_last = c_last.
  - On later accepts, m_last is ORed with c_last.
  - If the accept is at slot=3 or has c_last=1, the block goes to EMIT and records n = slot+1. Otherwise slot increments.
- padding_zero_M = (4-n)*CV_WORDS*W. For n = 4, 3, 2, 1 this gives 0, 1024, 2048, 3072.
- Unfilled slots hold zero, because the buffer is cleared on leaving EMIT.
- EMIT holds m_data and all qualifiers stable until m_valid && m_ready. That cycle the block clears the buffer, sets slot=0 and returns to FILL.
- Reset clears all state. A reset asserted mid-fill or mid-emit discards the partial block; no output is produced for it.

## Timing
- Reset values: c_ready=1, m_valid=0, m_data=0, m_level=0, m_index=0, m_last=0, padding_zero_M=0, err=0, state=FILL, slot=0.
- All outputs are registered.
- m_valid rises on the cycle after the completing accept.
- There is no bypass: in the cycle m_ready completes an EMIT, c_ready is still 0.
- A CV can be accepted from the next cycle onward, so minimum throughput is one block per FANIN+1 cycles.
- c_valid held while c_ready=0 causes no state change.
- c_last at slot=3 is a normal full block with n=4 and m_last=1.

## Configuration
- CF_COLLECT_CHECK_EN, defined: on each accept at slot s>0, the block sets err if any of these hold:
  - c_index[1:0] differs from s;
  - c_level differs from the level latched at slot 0;
  - c_index>>2 differs from m_index.

  It also sets err on a slot-0 accept with c_index[1:0]≠0, or with c_level=255 (the level would wrap). The offending CV is still stored. err stays set until reset.
- CF_COLLECT_CHECK_EN, undefined: err is tied to 0, no comparators are built, and c_index is used only at slot 0.

## Test plan
- Four CVs filled with 0x11.., 0x22.., 0x33.., 0x44.., at level 1 with indices 8..11, c_last=0, m_ready=1 → one cycle after the 4th accept: m_valid=1, m_data top quarter=0x11.., bottom quarter=0x44.., m_level=2, m_index=2, padding_zero_M=0, m_last=0.
- Single CV at index 12 with c_last=1 → m_data upper 16 words = CV, lower 48 words = 0, padding_zero_M=3072, m_last=1, m_index=3.
- Full block emitted with m_ready=0 for 5 cycles → m_valid, m_data and the qualifiers stay stable; c_ready=0 throughout; the handshake completes on the cycle m_ready=1; c_ready=1 on the next cycle.
- With CF_COLLECT_CHECK_EN defined: indices 0, 1, 3 → err=1 after the third accept and stays 1 through later blocks. With the macro undefined, the same stimulus gives err=0.
- rst_n dropped asynchronously after 2 accepts → outputs take reset values immediately. The next 4 CVs form a clean block with padding_zero_M=0 and no stale data.
- Two CVs with c_last on the 2nd → padding_zero_M=2048, slots 2-3 are zero. A following CV at slot 0 starts a fresh block correctly.

Source files
------------

// File: rtl/cf_output_collector.sv
// cf_output_collector: packs four consecutive CF chaining values into the next level's 64-word block.
// Optional CF_COLLECT_CHECK_EN builds the sticky index/level consistency checker driving err.
module cf_output_collector #(
   parameter int W        = 64,
   parameter int CV_WORDS = 16,
   parameter int FANIN    = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [CV_WORDS*W-1:0]    c_data,
   input  logic                     c_valid,
   output logic                     c_ready,
   input  logic [7:0]               c_level,
   input  logic [55:0]              c_index,
   input  logic                     c_last,
   output logic [64*W-1:0]          m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [7:0]               m_level,
   output logic [55:0]              m_index,
   output logic                     m_last,
   output logic [11:0]              padding_zero_M,
   output logic                     err
);
   localparam int CVW = CV_WORDS * W;
   typedef enum logic {FILL, EMIT} state_t;
   state_t          state_q, state_d;
   logic [1:0]      slot_q, slot_d;
   logic [64*W-1:0] buf_q, buf_d;
   logic [7:0]      level_q, level_d;
   logic [55:0]     index_q, index_d;
   logic            last_q, last_d;
   logic [11:0]     pad_q, pad_d;
   logic            accept;
   assign accept = (state_q == FILL) && c_valid;
   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      buf_d   = buf_q;
      level_d = level_q;
      index_d = index_q;
      last_d  = last_q;
      pad_d   = pad_q;
      if (state_q == EMIT) begin
         if (m_ready) begin
            state_d = FILL;
            slot_d  = 2'd0;
            buf_d   = '0;
         end
      end else if (c_valid) begin
         // first child lands in the most significant quarter
         for (int i = 0; i < FANIN; i++)
            if (slot_q == 2'(i)) buf_d[(FANIN-1-i)*CVW +: CVW] = c_data;
         level_d = (slot_q == 2'd0) ? c_level + 8'd1 : level_q;
         index_d = (slot_q == 2'd0) ? c_index >> 2 : index_q;
         last_d  = (slot_q == 2'd0) ? c_last : last_q | c_last;
         if (slot_q == 2'(FANIN-1) || c_last) begin
            state_d = EMIT;
            pad_d   = 12'((FANIN - 1 - int'(slot_q)) * CVW);
         end else begin
            slot_d = slot_q + 2'd1;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         slot_q  <= 2'd0;
         buf_q   <= '0;
         level_q <= 8'd0;
         index_q <= 56'd0;
         last_q  <= 1'b0;
         pad_q   <= 12'd0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         buf_q   <= buf_d;
         level_q <= level_d;
         index_q <= index_d;
         last_q  <= last_d;
         pad_q   <= pad_d;
      end
   end
   assign c_ready        = (state_q == FILL);
   assign m_valid        = (state_q == EMIT);
   assign m_data         = buf_q;
   assign m_level        = level_q;
   assign m_index        = index_q;
   assign m_last         = last_q;
   assign padding_zero_M = pad_q;
`ifdef CF_COLLECT_CHECK_EN
   logic err_q, err_d;
   logic bad;
   // level_q holds c_level+1, so siblings are compared against that
   assign bad = (slot_q == 2'd0) ? (c_index[1:0] != 2'd0 || c_level == 8'hFF)
                                 : (c_index[1:0] != slot_q || c_level + 8'd1 != level_q || (c_index >> 2) != index_q);
   always_comb err_d = err_q | (accept & bad);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end
   assign err = err_q;
`else
   logic unused_accept;
   assign unused_accept = accept;
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_cf_output_collector.sv
// tb_cf_output_collector: directed + randomized stimulus against a queue-based block model.
module tb_cf_output_collector;
   localparam int W   = 64;
   localparam int CVW = 16 * W;
`ifdef CF_COLLECT_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [CVW-1:0]  c_data = '0;
   logic            c_valid = 1'b0;
   logic            c_ready;
   logic [7:0]      c_level = '0;
   logic [55:0]     c_index = '0;
   logic            c_last = 1'b0;
   logic [64*W-1:0] m_data;
   logic            m_valid;
   logic            m_ready = 1'b1;
   logic [7:0]      m_level;
   logic [55:0]     m_index;
   logic            m_last;
   logic [11:0]     padding_zero_M;
   logic            err;
   int              n_vec = 0;
   int              n_err = 0;
   bit              rnd_mr = 1'b0;

   cf_output_collector dut (
      .clk(clk), .rst_n(rst_n), .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready),
      .c_level(c_level), .c_index(c_index), .c_last(c_last), .m_data(m_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_level(m_level), .m_index(m_index),
      .m_last(m_last), .padding_zero_M(padding_zero_M), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: list of accepted children, block assembled by concatenation.
   logic [CVW-1:0] kids [4];
   int             n_kids;
   bit             e_emit, e_last, e_err;
   logic [7:0]     e_lvl, lvl0;
   logic [55:0]    e_idx;
   logic [11:0]    e_pad;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_kids = 0; e_emit = 0; e_last = 0; e_err = 0;
         e_lvl = 0; e_idx = 0; e_pad = 0; lvl0 = 0;
         for (int i = 0; i < 4; i++) kids[i] = '0;
      end else if (e_emit) begin
         if (m_ready) begin
            e_emit = 0; n_kids = 0;
            for (int i = 0; i < 4; i++) kids[i] = '0;
         end
      end else if (c_valid) begin
         if (n_kids == 0) begin
            e_lvl = 8'((int'(c_level) + 1) % 256);
            e_idx = c_index / 4;
            e_last = c_last;
            lvl0 = c_level;
            if (CHK && (c_index % 4 != 0 || c_level == 8'd255)) e_err = 1;
         end else begin
            e_last = e_last | c_last;
            if (CHK && (c_index % 4 != 56'(n_kids) || c_level != lvl0 || c_index / 4 != e_idx)) e_err = 1;
         end
         kids[n_kids] = c_data;
         n_kids++;
         if (n_kids == 4 || c_last) begin
            e_emit = 1;
            e_pad = 12'((4 - n_kids) * 1024);
         end
      end
   end

   always @(negedge clk) begin
      logic [64*W-1:0] blk;
      check("c_ready", 64'(c_ready), 64'(!e_emit));
      check("m_valid", 64'(m_valid), 64'(e_emit));
      check("err", 64'(err), 64'(e_err));
      if (e_emit) begin
         blk = {kids[0], kids[1], kids[2], kids[3]};
         check("m_level", 64'(m_level), 64'(e_lvl));
         check("m_index", 64'(m_index), 64'(e_idx));
         check("m_last", 64'(m_last), 64'(e_last));
         check("padding", 64'(padding_zero_M), 64'(e_pad));
         for (int k = 0; k < 64; k++)
            check($sformatf("m_data_w%0d", k), m_data[k*W +: W], blk[k*W +: W]);
      end
   end

   always @(negedge clk) if (rnd_mr) m_ready = 1'($urandom_range(0, 1));

   function automatic logic [CVW-1:0] fill(input logic [7:0] b);
      return {128{b}};
   endfunction

   function automatic logic [CVW-1:0] rnd_cv();
      logic [CVW-1:0] v;
      for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Presents one CV and returns at the negedge after it has been accepted; c_valid stays high.
   task automatic send(input logic [CVW-1:0] d, input logic [7:0] lv, input logic [55:0] ix, input logic ls);
      int n = 0;
      c_data = d; c_level = lv; c_index = ix; c_last = ls; c_valid = 1'b1;
      while (!c_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("accept_timeout", 64'(c_ready), 64'd1);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      c_valid = 1'b0;
      c_data = rnd_cv();
      c_last = 1'($urandom_range(0, 1));
      repeat (n) @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 4; k++) send(fill(8'h11 * 8'(k + 1)), 8'd1, 56'(8 + k), 1'b0);
      idle(3);
      send(rnd_cv(), 8'd1, 56'd12, 1'b1);
      idle(3);
      m_ready = 1'b0;
      for (int k = 0; k < 4; k++) send(rnd_cv(), 8'd3, 56'(16 + k), 1'b0);
      c_data = rnd_cv();
      repeat (5) @(negedge clk);
      m_ready = 1'b1;
      idle(3);
      send(rnd_cv(), 8'd2, 56'd20, 1'b0);
      send(rnd_cv(), 8'd2, 56'd21, 1'b1);
      for (int k = 0; k < 4; k++) send(rnd_cv(), 8'd2, 56'(24 + k), k == 3);
      idle(3);
      send(rnd_cv(), 8'd5, 56'd0, 1'b0);
      send(rnd_cv(), 8'd5, 56'd1, 1'b0);
      send(rnd_cv(), 8'd5, 56'd3, 1'b1);
      idle(2);
      for (int k = 0; k < 4; k++) send(rnd_cv(), 8'd5, 56'(4 + k), 1'b0);
      idle(2);
      send(rnd_cv(), 8'd7, 56'd40, 1'b0);
      send(rnd_cv(), 8'd7, 56'd41, 1'b0);
      c_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_c_ready", 64'(c_ready), 64'd1);
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_m_data", 64'(|m_data), 64'd0);
      check("rst_m_level", 64'(m_level), 64'd0);
      check("rst_m_index", 64'(m_index), 64'd0);
      check("rst_m_last", 64'(m_last), 64'd0);
      check("rst_padding", 64'(padding_zero_M), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 4; k++) send(rnd_cv(), 8'd7, 56'(44 + k), 1'b0);
      idle(3);
      rnd_mr = 1'b1;
      for (int b = 0; b < 120; b++) begin
         logic [55:0] base = 56'($urandom_range(0, 100000)) * 56'd4;
         logic [7:0]  lv   = 8'($urandom_range(0, 255));
         int          n    = $urandom_range(1, 4);
         for (int k = 0; k < n; k++) begin
            logic [55:0] ix = base + 56'(k);
            if ($urandom_range(0, 19) == 0) ix = ix ^ 56'd1;
            send(rnd_cv(), lv, ix, (k == n - 1) && (n < 4 || $urandom_range(0, 1) == 1));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         end
      end
      rnd_mr = 1'b0;
      m_ready = 1'b1;
      idle(10);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
